pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_cap_pkg.sv | 13 +
 rtl/pwm_sync_edge.sv | 38 +++
 rtl/pwm_capture.sv | 155 +++++++++++++++
 tb/tb_pwm_capture.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_cap_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_cap_pkg;

   localparam int unsigned CntWDefault = 12;

   typedef enum logic [1:0] {
      StIdle,
      StArmed,
      StHigh,
      StLow
   } state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with rise/fall detection
// against the registered previous synchronized value.
module pwm_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = async_i;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~prev_q;
   assign fall_o  = ~sync_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a PWM input in clk cycles, flags a stuck
// input via timeout, and latches shoot-through between the two drives.
module pwm_capture
   import pwm_cap_pkg::*;
#(
   parameter int unsigned CNT_W = CntWDefault
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             pwm_in,
   input  logic             pwm_comp_in,
   input  logic             clear_fault,
   output logic [CNT_W-1:0] high_time,
   output logic [CNT_W-1:0] period,
   output logic             meas_valid,
   output logic             timeout,
   output logic             stuck_level,
   output logic             overlap_fault
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic pwm_lvl, pwm_rise, pwm_fall;
   logic comp_lvl;
   logic overlap;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
   logic [CNT_W-1:0] high_time_q, high_time_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             meas_valid_q, meas_valid_d;
   logic             timeout_q, timeout_d;
   logic             stuck_q, stuck_d;
   logic             fault_q, fault_d;

   pwm_sync_edge u_sync_pwm (
      .clk     (clk),
      .rst     (rst),
      .async_i (pwm_in),
      .level_o (pwm_lvl),
      .rise_o  (pwm_rise),
      .fall_o  (pwm_fall)
   );

   pwm_sync_edge u_sync_comp (
      .clk     (clk),
      .rst     (rst),
      .async_i (pwm_comp_in),
      .level_o (comp_lvl),
      .rise_o  (),
      .fall_o  ()
   );

   assign overlap = pwm_lvl & comp_lvl;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hi_cap_d     = hi_cap_q;
      high_time_d  = high_time_q;
      period_d     = period_q;
      meas_valid_d = 1'b0;
      timeout_d    = timeout_q;
      stuck_d      = stuck_q;
      fault_d      = fault_q;

      if (!en) begin
         // Disabled: idle and discard the partial count, keep last results.
         state_d   = StIdle;
         cnt_d     = '0;
         timeout_d = 1'b0;
      end else begin
         if (pwm_rise) begin
            cnt_d = CntOne;
         end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CntOne;
         end

         unique case (state_q)
            StIdle: state_d = StArmed;
            StArmed: begin
               if (pwm_rise) begin
                  state_d   = StHigh;
                  timeout_d = 1'b0;
               end
            end
            StHigh: begin
               if (cnt_q == CntMax) begin
                  state_d   = StArmed;
                  timeout_d = 1'b1;
                  stuck_d   = pwm_lvl;
               end else if (pwm_fall) begin
                  state_d  = StLow;
                  hi_cap_d = cnt_q;
               end
            end
            StLow: begin
               if (cnt_q == CntMax) begin
                  state_d   = StArmed;
                  timeout_d = 1'b1;
                  stuck_d   = pwm_lvl;
               end else if (pwm_rise) begin
                  state_d      = StHigh;
                  period_d     = cnt_q;
                  high_time_d  = hi_cap_q;
                  meas_valid_d = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase

         // Set has priority so a clear cannot hide an ongoing shoot-through.
         if (overlap) begin
            fault_d = 1'b1;
         end else if (clear_fault) begin
            fault_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         hi_cap_q     <= '0;
         high_time_q  <= '0;
         period_q     <= '0;
         meas_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
         stuck_q      <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hi_cap_q     <= hi_cap_d;
         high_time_q  <= high_time_d;
         period_q     <= period_d;
         meas_valid_q <= meas_valid_d;
         timeout_q    <= timeout_d;
         stuck_q      <= stuck_d;
         fault_q      <= fault_d;
      end
   end

   assign high_time     = high_time_q;
   assign period        = period_q;
   assign meas_valid    = meas_valid_q;
   assign timeout       = timeout_q;
   assign stuck_level   = stuck_q;
   assign overlap_fault = fault_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: periodic capture, timeout, overlap fault,
// reset and enable behaviour, minimum pulse width.
module tb_pwm_capture;

   localparam int unsigned CW = 12;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          pwm_in;
   logic          pwm_comp_in;
   logic          clear_fault;
   logic [CW-1:0] high_time;
   logic [CW-1:0] period;
   logic          meas_valid;
   logic          timeout;
   logic          stuck_level;
   logic          overlap_fault;

   int checks = 0;
   int errors = 0;

   int            mv_count    = 0;
   int            cyc         = 0;
   int            last_mv_cyc = 0;
   int            last_gap    = 0;
   logic [CW-1:0] last_h      = '0;
   logic [CW-1:0] last_p      = '0;

   always #5 clk = ~clk;

   pwm_capture #(.CNT_W(CW)) dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .pwm_in        (pwm_in),
      .pwm_comp_in   (pwm_comp_in),
      .clear_fault   (clear_fault),
      .high_time     (high_time),
      .period        (period),
      .meas_valid    (meas_valid),
      .timeout       (timeout),
      .stuck_level   (stuck_level),
      .overlap_fault (overlap_fault)
   );

   // Strobe recorder; tasks act 1 time unit after each falling edge.
   always @(negedge clk) begin
      cyc++;
      if (meas_valid === 1'b1) begin
         mv_count++;
         last_gap    = cyc - last_mv_cyc;
         last_mv_cyc = cyc;
         last_h      = high_time;
         last_p      = period;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic drive_pulse(input int h, input int p);
      pwm_in = 1'b1;
      tick(h);
      pwm_in = 1'b0;
      tick(p - h);
   endtask

   task automatic test_reset;
      rst = 1'b1; en = 1'b0; pwm_in = 1'b0; pwm_comp_in = 1'b0; clear_fault = 1'b0;
      tick(3);
      checks++;
      if ({high_time, period, meas_valid, timeout, stuck_level, overlap_fault} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ht=%0d per=%0d mv=%b to=%b sl=%b of=%b required all 0",
                  high_time, period, meas_valid, timeout, stuck_level, overlap_fault);
      end
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_periodic;
      int base;
      en = 1'b1;
      tick(5);
      base = mv_count;
      for (int i = 0; i < 4; i++) drive_pulse(64, 256);
      checks++;
      if (mv_count - base !== 3) begin
         errors++;
         $display("FAIL periodic_count: got %0d required 3", mv_count - base);
      end
      checks++;
      if (last_h !== 12'd64) begin
         errors++;
         $display("FAIL periodic_high: got %0d required 64", last_h);
      end
      checks++;
      if (last_p !== 12'd256) begin
         errors++;
         $display("FAIL periodic_period: got %0d required 256", last_p);
      end
      checks++;
      if (last_gap !== 256) begin
         errors++;
         $display("FAIL periodic_gap: got %0d required 256", last_gap);
      end
      pwm_in = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         checks++;
         if (meas_valid !== (k == 3)) begin
            errors++;
            $display("FAIL latency_cycle%0d: got %b required %b", k, meas_valid, (k == 3));
         end
      end
      tick(60);
      pwm_in = 1'b0;
      tick(192);
      checks++;
      if ({timeout, overlap_fault} !== 2'b00) begin
         errors++;
         $display("FAIL periodic_faults: got to=%b of=%b required 0 0", timeout, overlap_fault);
      end
   endtask

   task automatic test_timeout;
      int base;
      en = 1'b0;
      tick(3);
      en = 1'b1;
      tick(3);
      base = mv_count;
      pwm_in = 1'b1;
      tick(4097);
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: got %b required 0", timeout);
      end
      tick(1);
      checks++;
      if ({timeout, stuck_level} !== 2'b11) begin
         errors++;
         $display("FAIL timeout_set: got to=%b sl=%b required 1 1", timeout, stuck_level);
      end
      tick(5000 - 4098);
      pwm_in = 1'b0;
      checks++;
      if (mv_count - base !== 0) begin
         errors++;
         $display("FAIL timeout_no_meas: got %0d strobes required 0", mv_count - base);
      end
      tick(100);
      pwm_in = 1'b1;
      tick(2);
      checks++;
      if (timeout !== 1'b1) begin
         errors++;
         $display("FAIL timeout_hold: got %b required 1", timeout);
      end
      tick(1);
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_clear: got %b required 0", timeout);
      end
      tick(27);
      pwm_in = 1'b0;
      tick(70);
      pwm_in = 1'b1;
      tick(4);
      checks++;
      if (mv_count - base !== 1 || last_h !== 12'd30 || last_p !== 12'd100) begin
         errors++;
         $display("FAIL timeout_recover: got n=%0d ht=%0d per=%0d required n=1 ht=30 per=100",
                  mv_count - base, last_h, last_p);
      end
      tick(26);
      pwm_in = 1'b0;
      tick(20);
   endtask

   task automatic test_overlap;
      pwm_in = 1'b1; pwm_comp_in = 1'b1;
      tick(2);
      checks++;
      if (overlap_fault !== 1'b0) begin
         errors++;
         $display("FAIL overlap_early: got %b required 0", overlap_fault);
      end
      tick(1);
      checks++;
      if (overlap_fault !== 1'b1) begin
         errors++;
         $display("FAIL overlap_set: got %b required 1", overlap_fault);
      end
      pwm_in = 1'b0; pwm_comp_in = 1'b0; clear_fault = 1'b1;
      tick(1);
      clear_fault = 1'b0;
      checks++;
      if (overlap_fault !== 1'b1) begin
         errors++;
         $display("FAIL overlap_clear_during: got %b required 1", overlap_fault);
      end
      tick(10);
      checks++;
      if (overlap_fault !== 1'b1) begin
         errors++;
         $display("FAIL overlap_sticky: got %b required 1", overlap_fault);
      end
      clear_fault = 1'b1;
      tick(1);
      clear_fault = 1'b0;
      checks++;
      if (overlap_fault !== 1'b0) begin
         errors++;
         $display("FAIL overlap_cleared: got %b required 0", overlap_fault);
      end
      tick(5);
   endtask

   task automatic test_reset_mid;
      int base;
      drive_pulse(20, 50);
      drive_pulse(20, 50);
      pwm_in = 1'b1;
      tick(10);
      checks++;
      if (high_time !== 12'd20) begin
         errors++;
         $display("FAIL pre_reset_high: got %0d required 20", high_time);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({high_time, period, meas_valid, timeout, stuck_level, overlap_fault} !== '0) begin
         errors++;
         $display("FAIL reset_async: got ht=%0d per=%0d mv=%b to=%b sl=%b of=%b required all 0",
                  high_time, period, meas_valid, timeout, stuck_level, overlap_fault);
      end
      tick(5);
      pwm_in = 1'b0;
      tick(5);
      rst = 1'b0;
      tick(5);
      base = mv_count;
      drive_pulse(20, 50);
      checks++;
      if (mv_count - base !== 0) begin
         errors++;
         $display("FAIL reset_first_rise: got %0d strobes required 0", mv_count - base);
      end
      pwm_in = 1'b1;
      tick(4);
      checks++;
      if (mv_count - base !== 1 || last_h !== 12'd20 || last_p !== 12'd50) begin
         errors++;
         $display("FAIL reset_second_rise: got n=%0d ht=%0d per=%0d required n=1 ht=20 per=50",
                  mv_count - base, last_h, last_p);
      end
      tick(16);
      pwm_in = 1'b0;
      tick(30);
   endtask

   task automatic test_en_drop;
      int base;
      drive_pulse(30, 80);
      drive_pulse(30, 80);
      pwm_in = 1'b1;
      tick(30);
      pwm_in = 1'b0;
      tick(20);
      base = mv_count;
      en = 1'b0;
      tick(100);
      checks++;
      if (mv_count - base !== 0 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL en_low_quiet: got n=%0d to=%b required n=0 to=0", mv_count - base, timeout);
      end
      checks++;
      if (high_time !== 12'd30 || period !== 12'd80) begin
         errors++;
         $display("FAIL en_low_hold: got ht=%0d per=%0d required ht=30 per=80", high_time, period);
      end
      en = 1'b1;
      tick(10);
      drive_pulse(25, 70);
      checks++;
      if (mv_count - base !== 0) begin
         errors++;
         $display("FAIL en_first_rise: got %0d strobes required 0", mv_count - base);
      end
      pwm_in = 1'b1;
      tick(4);
      checks++;
      if (mv_count - base !== 1 || last_h !== 12'd25 || last_p !== 12'd70) begin
         errors++;
         $display("FAIL en_second_rise: got n=%0d ht=%0d per=%0d required n=1 ht=25 per=70",
                  mv_count - base, last_h, last_p);
      end
      tick(21);
      pwm_in = 1'b0;
      tick(30);
   endtask

   task automatic test_min_pulse;
      int base;
      base = mv_count;
      for (int i = 0; i < 5; i++) begin
         drive_pulse(1, 10);
         if (i > 0) begin
            checks++;
            if (last_h !== 12'd1 || last_p !== 12'd10) begin
               errors++;
               $display("FAIL min_pulse_%0d: got ht=%0d per=%0d required ht=1 per=10",
                        i, last_h, last_p);
            end
         end
      end
      checks++;
      if (mv_count - base !== 5) begin
         errors++;
         $display("FAIL min_pulse_count: got %0d required 5", mv_count - base);
      end
   endtask

   initial begin
      test_reset;
      test_periodic;
      test_timeout;
      test_overlap;
      test_reset_mid;
      test_en_drop;
      test_min_pulse;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout at %0t required completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
